// File: rtl/channel_pkg.sv
// channel_pkg: shared types, constants and arithmetic helpers for the
// channel_iir_model lossy-channel emulator.
//   DATA_W / COEF_W : sample width (signed) and pole coefficient width (Q0.COEF_W)
//   FS              : full-scale level, 2^(DATA_W-1)-1
//   ALPHA_RST_DEF   : default pole coefficient (~0.811)
//   map_bit()       : NRZ bit -> signed level
//   iir_step()      : one first-order low-pass update with round-half-up
package channel_pkg;
  localparam int DATA_W        = 16;
  localparam int COEF_W        = 16;
  localparam int FS            = 2**(DATA_W-1) - 1;
  localparam int ALPHA_RST_DEF = 53150;
  localparam int PROD_W        = DATA_W + COEF_W + 2;
  localparam int STEP_W        = PROD_W - COEF_W;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic        [COEF_W-1:0] coef_t;
  typedef logic        [COEF_W:0]   beta_t;   // 2^COEF_W - alpha, needs one extra bit

  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (COEF_W-1);

  function automatic sample_t map_bit(input logic b, input logic bipolar);
    sample_t lvl;
    if (b)            lvl = sample_t'(FS);
    else if (bipolar) lvl = sample_t'(-FS);
    else              lvl = '0;
    return lvl;
  endfunction

  // y + round(((x - y) * beta) / 2^COEF_W), clamped to +/-FS.
  // The clamp is defensive: the update is a convex blend of x and y.
  function automatic sample_t iir_step(input sample_t y, input sample_t x, input beta_t beta);
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [STEP_W-1:0] step;
    logic signed [STEP_W:0]   sum;
    sample_t                  res;
    diff = {x[DATA_W-1], x} - {y[DATA_W-1], y};
    prod = PROD_W'(diff) * $signed(PROD_W'(beta));
    prod = prod + RND_HALF;
    step = STEP_W'(prod >>> COEF_W);
    sum  = (STEP_W+1)'(y) + (STEP_W+1)'(step);
    if (sum > (STEP_W+1)'(FS))       res = sample_t'(FS);
    else if (sum < (STEP_W+1)'(-FS)) res = sample_t'(-FS);
    else                             res = sample_t'(sum);
    return res;
  endfunction
endpackage

// File: rtl/channel_iir_model_pole.sv
// iir_pole: one registered first-order low-pass pole.
//   clk  : sample clock (rising edge)
//   Rst  : synchronous active-high reset, clears the state to 0
//   x    : stage input (previous stage output or delayed input level)
//   beta : 2^COEF_W - alpha, shared by all stages
//   y    : registered stage output
module iir_pole
  import channel_pkg::*;
(
  input  logic    clk,
  input  logic    Rst,
  input  sample_t x,
  input  beta_t   beta,
  output sample_t y
);
  sample_t y_q, y_d;

  always_comb y_d = iir_step(y_q, x, beta);

  always_ff @(posedge clk) begin
    if (Rst) y_q <= '0;
    else     y_q <= y_d;
  end

  assign y = y_q;
endmodule

// File: rtl/channel_iir_model.sv
// channel_iir_model: fixed-point lossy-channel emulator. Holds each NRZ bit
// for N oversamples, maps it to a signed level and runs it through STAGES
// cascaded first-order poles sharing a runtime-loadable coefficient.
//   Sample_CLK : oversampling clock, all state on its rising edge
//   Rst        : synchronous active-high reset
//   Data_in    : serial bit, sampled when UI_phase == 0
//   Coef_ld    : loads Coef_in into alpha (ignored during Rst)
//   Coef_in    : new alpha, unsigned Q0.COEF_W
//   Bypass     : selects the unfiltered level, latency-matched to the filter
//   Data_out   : signed attenuated sample
//   Out_valid  : high once the pipeline has filled after reset
//   UI_strobe  : high during the last oversample of each UI
//   UI_phase   : oversample index within the UI
// DATA_W and COEF_W are fixed in channel_pkg.
module channel_iir_model
  import channel_pkg::*;
#(
  parameter int N         = 10,
  parameter int STAGES    = 1,
  parameter int BIPOLAR   = 0,
  parameter int ALPHA_RST = ALPHA_RST_DEF
)(
  input  logic                               Sample_CLK,
  input  logic                               Rst,
  input  logic                               Data_in,
  input  logic                               Coef_ld,
  input  logic [COEF_W-1:0]                  Coef_in,
  input  logic                               Bypass,
  output logic signed [DATA_W-1:0]           Data_out,
  output logic                               Out_valid,
  output logic                               UI_strobe,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] UI_phase
);
  localparam int            PW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] LAST = PW'(N-1);

  logic [PW-1:0] phase_q, phase_d;
  logic          strobe_q, strobe_d;
  sample_t       u_new_q, u_new_d;
  // dly_q[0] is u_old; dly_q[STAGES] is the bypass tap. The extra STAGES
  // registers line the raw level up with the output of the last pole.
  sample_t       dly_q [STAGES+1];
  sample_t       dly_d [STAGES+1];
  coef_t         alpha_q, alpha_d;
  beta_t         beta;
  logic [2:0]    fill_q, fill_d;
  logic          valid_q, valid_d;

  logic [STAGES:0][DATA_W-1:0] stage_x;

  always_comb begin
    phase_d  = (phase_q == LAST) ? '0 : phase_q + PW'(1);
    strobe_d = (phase_d == LAST);
    u_new_d  = (phase_q == '0) ? map_bit(Data_in, BIPOLAR != 0) : u_new_q;
    dly_d[0] = u_new_q;
    for (int k = 1; k <= STAGES; k++) dly_d[k] = dly_q[k-1];
    alpha_d  = Coef_ld ? Coef_in : alpha_q;
    // Out_valid rises on the (STAGES+1)th edge out of reset.
    fill_d   = (fill_q == 3'(STAGES)) ? fill_q : fill_q + 3'd1;
    valid_d  = valid_q | (fill_q == 3'(STAGES));
  end

  always_ff @(posedge Sample_CLK) begin
    if (Rst) begin
      phase_q  <= '0;
      strobe_q <= 1'b0;
      u_new_q  <= '0;
      for (int k = 0; k <= STAGES; k++) dly_q[k] <= '0;
      alpha_q  <= coef_t'(ALPHA_RST);
      fill_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
      u_new_q  <= u_new_d;
      dly_q    <= dly_d;
      alpha_q  <= alpha_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
    end
  end

  // A coefficient loaded on this edge only reaches beta after the edge.
  assign beta       = {1'b1, {COEF_W{1'b0}}} - {1'b0, alpha_q};
  assign stage_x[0] = dly_q[0];

  for (genvar k = 1; k <= STAGES; k++) begin : g_pole
    iir_pole u_pole (
      .clk  (Sample_CLK),
      .Rst  (Rst),
      .x    (stage_x[k-1]),
      .beta (beta),
      .y    (stage_x[k])
    );
  end

  // Pure mux: the pole cascade keeps running while bypassed.
  assign Data_out  = Bypass ? dly_q[STAGES] : sample_t'(stage_x[STAGES]);
  assign Out_valid = valid_q;
  assign UI_strobe = strobe_q;
  assign UI_phase  = phase_q;
endmodule

// File: tb/tb_channel_iir_model.sv
// Self-checking bench for channel_iir_model. Two instances: A (N=10,
// STAGES=1, unipolar) and B (N=1, STAGES=3, bipolar), each tracked by a
// behavioural model built from edge counts and integer arithmetic.
module tb_channel_iir_model;
  localparam int     NA  = 10;
  localparam int     SA  = 1;
  localparam int     NB  = 1;
  localparam int     SB  = 3;
  localparam longint FSV = 32767;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               a_rst, a_din, a_ld, a_byp;
  logic [15:0]        a_cin;
  logic signed [15:0] a_dout;
  logic               a_vld, a_stb;
  logic [3:0]         a_ph;

  logic               b_rst, b_din, b_ld, b_byp;
  logic [15:0]        b_cin;
  logic signed [15:0] b_dout;
  logic               b_vld, b_stb;
  logic [0:0]         b_ph;

  channel_iir_model #(.N(NA), .STAGES(SA), .BIPOLAR(0), .ALPHA_RST(53150)) dut_a (
    .Sample_CLK(clk), .Rst(a_rst), .Data_in(a_din), .Coef_ld(a_ld), .Coef_in(a_cin),
    .Bypass(a_byp), .Data_out(a_dout), .Out_valid(a_vld), .UI_strobe(a_stb), .UI_phase(a_ph));

  channel_iir_model #(.N(NB), .STAGES(SB), .BIPOLAR(1), .ALPHA_RST(53150)) dut_b (
    .Sample_CLK(clk), .Rst(b_rst), .Data_in(b_din), .Coef_ld(b_ld), .Coef_in(b_cin),
    .Bypass(b_byp), .Data_out(b_dout), .Out_valid(b_vld), .UI_strobe(b_stb), .UI_phase(b_ph));

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: edges since reset, captured level, the raw
  // level history (pipe[0] = one edge old) and each pole output.
  longint m_unew  [2];
  longint m_pipe  [2][5];
  longint m_y     [2][4];
  longint m_alpha [2];
  int     m_cnt   [2];

  function automatic longint lvl(input logic b, input bit bip);
    return b ? FSV : (bip ? -FSV : 64'sd0);
  endfunction

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  task automatic mstep(input int i, input int n, input int st, input bit bip,
                       input logic rst, input logic din, input logic ld, input longint cin);
    longint ny [4];
    longint x, beta;
    if (rst) begin
      m_cnt[i] = 0; m_unew[i] = 0; m_alpha[i] = 53150;
      for (int k = 0; k < 5; k++) m_pipe[i][k] = 0;
      for (int k = 0; k < 4; k++) m_y[i][k] = 0;
    end else begin
      beta = 65536 - m_alpha[i];
      for (int k = 0; k < st; k++) begin
        if (k == 0) x = m_pipe[i][0];
        else        x = m_y[i][k-1];
        ny[k] = m_y[i][k] + fdiv((x - m_y[i][k]) * beta + 32768, 65536);
        if (ny[k] > FSV)  ny[k] = FSV;
        if (ny[k] < -FSV) ny[k] = -FSV;
      end
      for (int k = 0; k < st; k++) m_y[i][k] = ny[k];
      for (int k = 4; k > 0; k--) m_pipe[i][k] = m_pipe[i][k-1];
      m_pipe[i][0] = m_unew[i];
      if (m_cnt[i] % n == 0) m_unew[i] = lvl(din, bip);
      m_cnt[i] = m_cnt[i] + 1;
      if (ld) m_alpha[i] = cin;
    end
  endtask

  task automatic tick();
    mstep(0, NA, SA, 1'b0, a_rst, a_din, a_ld, longint'(a_cin));
    mstep(1, NB, SB, 1'b1, b_rst, b_din, b_ld, longint'(b_cin));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [21:0] exp_a();
    longint v;
    v = a_byp ? m_pipe[0][SA] : m_y[0][SA-1];
    return {16'(v), 4'(m_cnt[0] % NA), (m_cnt[0] % NA == NA-1), (m_cnt[0] >= SA+1)};
  endfunction

  function automatic logic [18:0] exp_b();
    longint v;
    v = b_byp ? m_pipe[1][SB] : m_y[1][SB-1];
    return {16'(v), 1'(m_cnt[1] % NB), (m_cnt[1] % NB == NB-1), (m_cnt[1] >= SB+1)};
  endfunction

  task automatic test_reset();
    a_rst = 1; b_rst = 1; a_ld = 1; a_cin = 16'h1234; b_ld = 1; b_cin = 16'h0042;
    a_din = 1; b_din = 1;
    tick(); tick(); tick();
    n_cmp++;
    if ({a_dout, a_ph, a_stb, a_vld} !== 22'd0) begin
      n_err++; $display("FAIL reset_a: got %h expected 0", {a_dout, a_ph, a_stb, a_vld});
    end
    n_cmp++;
    if ({b_dout, b_ph, b_stb, b_vld} !== 19'd0) begin
      n_err++; $display("FAIL reset_b: got %h expected 0", {b_dout, b_ph, b_stb, b_vld});
    end
    a_ld = 0; b_ld = 0; a_din = 0; b_din = 0;
  endtask

  task automatic test_step();
    longint prev, c;
    prev = 0;
    a_rst = 0;
    for (int i = 1; i <= 30; i++) begin
      a_din = (i > 10);
      tick();
      n_cmp++;
      if ({a_dout, a_ph, a_stb, a_vld} !== exp_a()) begin
        n_err++; $display("FAIL step_model edge %0d: got %h expected %h", i, {a_dout, a_ph, a_stb, a_vld}, exp_a());
      end
      n_cmp++;
      if (a_vld !== (i >= 2)) begin
        n_err++; $display("FAIL step_valid edge %0d: got %b expected %b", i, a_vld, (i >= 2));
      end
      if (i <= 14) begin
        c = (i < 13) ? 0 : ((i == 13) ? 6193 : 11215);
        n_cmp++;
        if (a_dout !== 16'(c)) begin
          n_err++; $display("FAIL step_value edge %0d: got %0d expected %0d", i, a_dout, c);
        end
      end else begin
        n_cmp++;
        if (a_dout < prev || a_dout < 0) begin
          n_err++; $display("FAIL step_monotonic edge %0d: got %0d after %0d", i, a_dout, prev);
        end
      end
      prev = a_dout;
    end
  endtask

  task automatic test_coef_zero();
    longint cap [$];
    a_ld = 1; a_cin = 16'd0; a_din = 0;
    cap.push_back(m_unew[0]);
    tick();
    cap.push_back(m_unew[0]);
    a_ld = 0;
    for (int j = 2; j <= 41; j++) begin
      a_din = 1'($urandom_range(1));
      tick();
      cap.push_back(m_unew[0]);
      n_cmp++;
      if ({a_dout, a_ph, a_stb, a_vld} !== exp_a()) begin
        n_err++; $display("FAIL coef0_model edge %0d: got %h expected %h", j, {a_dout, a_ph, a_stb, a_vld}, exp_a());
      end
      n_cmp++;
      if (a_dout !== 16'(cap[j-2])) begin
        n_err++; $display("FAIL coef0_delay edge %0d: got %0d expected %0d", j, a_dout, cap[j-2]);
      end
      a_byp = 1; #1;
      n_cmp++;
      if (a_dout !== 16'(cap[j-2])) begin
        n_err++; $display("FAIL coef0_bypass edge %0d: got %0d expected %0d", j, a_dout, cap[j-2]);
      end
      a_byp = 0; #1;
    end
  endtask

  task automatic test_toggle();
    int         nstb;
    logic [3:0] pph;
    nstb = 0;
    pph  = a_ph;
    for (int i = 0; i < 30; i++) begin
      a_din = 1'(i % 2);
      tick();
      n_cmp++;
      if ({a_dout, a_ph, a_stb, a_vld} !== exp_a()) begin
        n_err++; $display("FAIL toggle_model step %0d: got %h expected %h", i, {a_dout, a_ph, a_stb, a_vld}, exp_a());
      end
      if (pph == 4'd9) begin
        n_cmp++;
        if (a_ph !== 4'd0) begin
          n_err++; $display("FAIL toggle_wrap step %0d: got %0d expected 0", i, a_ph);
        end
      end
      nstb += int'(a_stb);
      pph = a_ph;
    end
    n_cmp++;
    if (nstb != 3) begin
      n_err++; $display("FAIL toggle_strobes: got %0d expected 3", nstb);
    end
  endtask

  task automatic test_reset_mid();
    a_rst = 1; tick();
    a_rst = 0; a_din = 1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if ({a_dout, a_ph, a_stb, a_vld} !== exp_a()) begin
        n_err++; $display("FAIL mid_model edge %0d: got %h expected %h", i, {a_dout, a_ph, a_stb, a_vld}, exp_a());
      end
    end
    n_cmp++;
    if (a_ph !== 4'd5) begin
      n_err++; $display("FAIL mid_phase: got %0d expected 5", a_ph);
    end
    a_rst = 1; a_ld = 1; a_cin = 16'd7;
    tick();
    n_cmp++;
    if ({a_dout, a_ph, a_stb, a_vld} !== 22'd0) begin
      n_err++; $display("FAIL mid_reset: got %h expected 0", {a_dout, a_ph, a_stb, a_vld});
    end
    a_rst = 0; a_ld = 0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_cmp++;
      if ({a_dout, a_ph, a_stb, a_vld} !== exp_a()) begin
        n_err++; $display("FAIL mid_rerun edge %0d: got %h expected %h", i, {a_dout, a_ph, a_stb, a_vld}, exp_a());
      end
    end
    n_cmp++;
    if (a_dout !== 16'sd6193) begin
      n_err++; $display("FAIL mid_alpha: got %0d expected 6193", a_dout);
    end
  endtask

  task automatic test_bipolar_delay();
    logic   d [$];
    longint ev;
    b_rst = 0; b_ld = 1; b_cin = 16'd0; b_din = 0;
    tick();
    d.push_back(1'b0);
    b_ld = 0;
    for (int j = 1; j <= 24; j++) begin
      b_din = 1'(j % 2);
      d.push_back(b_din);
      tick();
      n_cmp++;
      if ({b_dout, b_ph, b_stb, b_vld} !== exp_b()) begin
        n_err++; $display("FAIL bip_model edge %0d: got %h expected %h", j, {b_dout, b_ph, b_stb, b_vld}, exp_b());
      end
      ev = (j < 4) ? 0 : lvl(d[j-4], 1'b1);
      n_cmp++;
      if (b_dout !== 16'(ev)) begin
        n_err++; $display("FAIL bip_filter edge %0d: got %0d expected %0d", j, b_dout, ev);
      end
      b_byp = 1; #1;
      n_cmp++;
      if (b_dout !== 16'(ev)) begin
        n_err++; $display("FAIL bip_bypass edge %0d: got %0d expected %0d", j, b_dout, ev);
      end
      b_byp = 0; #1;
      n_cmp++;
      if ({b_vld, b_stb} !== {(j >= 3), 1'b1}) begin
        n_err++; $display("FAIL bip_flags edge %0d: got %b%b expected %b1", j, b_vld, b_stb, (j >= 3));
      end
    end
  endtask

  task automatic test_random();
    real yr [3];
    real nyr [3];
    real br, x, e, maxe;
    maxe = 0.0;
    for (int k = 0; k < 3; k++) yr[k] = 0.0;
    b_rst = 1; tick();
    b_rst = 0; b_ld = 1; b_cin = 16'd32768; tick();
    b_ld = 0;
    for (int j = 0; j < 2000; j++) begin
      b_din = 1'($urandom_range(1));
      br = real'(65536 - m_alpha[1]) / 65536.0;
      for (int k = 0; k < 3; k++) begin
        if (k == 0) x = real'(m_pipe[1][0]);
        else        x = yr[k-1];
        nyr[k] = yr[k] + (x - yr[k]) * br;
      end
      yr = nyr;
      tick();
      n_cmp++;
      if ({b_dout, b_ph, b_stb, b_vld} !== exp_b()) begin
        n_err++; $display("FAIL rand_model edge %0d: got %h expected %h", j, {b_dout, b_ph, b_stb, b_vld}, exp_b());
      end
      e = real'(b_dout) - yr[2];
      if (e < 0.0) e = -e;
      if (e > maxe) maxe = e;
    end
    n_cmp++;
    if (maxe > 2.0 * SB) begin
      n_err++; $display("FAIL rand_real_error: got %f LSB allowed %0d", maxe, 2 * SB);
    end
  endtask

  initial begin
    a_rst = 1; b_rst = 1; a_din = 0; b_din = 0; a_ld = 0; b_ld = 0;
    a_cin = '0; b_cin = '0; a_byp = 0; b_byp = 0;
    test_reset();
    test_step();
    test_coef_zero();
    test_toggle();
    test_reset_mid();
    test_bipolar_delay();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
